// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared defaults, counter width and fetch-entry type for the prefetch stage
package ifetch_pkg;
  localparam int DEFAULT_DEPTH = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int CNT_W = $clog2(DEFAULT_DEPTH + 1);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction
endpackage

// File: rtl/ifetch_prefetch_if.sv
// ifetch_prefetch_if: memory request/response, core redirect and instruction delivery signals
interface ifetch_prefetch_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  modport master (
    output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );
  modport slave (
    input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: in-order buffer of fetched {pc, instr} entries with flush; flush beats push and pop
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0 && !flush;
  assign do_push = push && !flush && (count < CW'(DEPTH) || do_pop);
  assign head = mem[rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + AW'(1);
      end
      if (do_pop) rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !flush) |-> (count < CW'(DEPTH) || do_pop));
endmodule

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: credit-limited instruction prefetcher feeding the core through a PC-tagged FIFO
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic clk,
  input logic rst_n,
  ifetch_prefetch_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0] fetch_pc, rsp_pc, target;
  logic [CW-1:0] inflight, inflight_next, drop_cnt, fifo_count;
  logic req_fire, keep, pop, credit;
  fetch_entry_t din, head;
  assign target = align_pc(bus.redirect_pc);
  // buffered plus outstanding words never exceed DEPTH, so every response has a slot
  assign credit = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(DEPTH);
  assign bus.mem_req_valid = rst_n && !bus.redirect_valid && credit;
  assign bus.mem_req_addr = fetch_pc;
  assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
  assign keep = bus.mem_rsp_valid && drop_cnt == '0;
  assign pop = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;
  assign inflight_next = inflight + CW'(req_fire) - CW'(bus.mem_rsp_valid);
  assign din = '{pc: rsp_pc, instr: bus.mem_rsp_data};
  assign bus.instr_valid = fifo_count != '0;
  assign bus.instr = bus.instr_valid ? head.instr : '0;
  assign bus.instr_pc = bus.instr_valid ? head.pc : '0;
  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (din),
    .head  (head),
    .count (fifo_count)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight_next;
      if (bus.redirect_valid) begin
        fetch_pc <= target;
        rsp_pc <= target;
        drop_cnt <= inflight_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (keep) rsp_pc <= rsp_pc + 32'd4;
        if (bus.mem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end
  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    bus.mem_rsp_valid |-> inflight != '0);
  a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    bus.mem_req_addr[1:0] == 2'b00);
endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb_ifetch_prefetch: randomized scoreboard bench with an in-order variable-latency memory model
module tb_ifetch_prefetch;
  localparam int DEPTH = 4;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  typedef struct {
    int          t;
    logic [31:0] d;
    bit          stale;
  } rsp_t;
  logic clk = 0;
  logic rst_n = 0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_t = 0;
  int acc_cnt = 0;
  int lat_min = 1;
  int lat_max = 1;
  bit cur_stale = 0;
  bit prev_stall = 0;
  bit prev_redir = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] exp_fetch = '0;
  logic [31:0] sbq[$];
  rsp_t mq[$];
  ifetch_prefetch_if bus ();
  ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit rr, input bit ir, input bit rv, input logic [31:0] rp);
    @(posedge clk);
    #1;
    cyc++;
    if (mq.size() > 0 && mq[0].t <= cyc) begin
      bus.mem_rsp_valid = 1;
      bus.mem_rsp_data = mq[0].d;
      cur_stale = mq[0].stale;
      mq.delete(0);
    end else begin
      bus.mem_rsp_valid = 0;
      bus.mem_rsp_data = $urandom;
      cur_stale = 0;
    end
    bus.mem_req_ready = rr;
    bus.instr_ready = ir;
    bus.redirect_valid = rv;
    bus.redirect_pc = rp;
  endtask

  task automatic run(input int n, input bit rr, input bit ir);
    for (int k = 0; k < n; k++) step(rr, ir, 0, 32'h0);
  endtask

  // asserts reset mid-cycle, checks the asynchronous output clear, releases just after a rising edge
  task automatic do_reset(input bit rr, input bit ir);
    #2 rst_n = 0;
    #1;
    chk("rst_instr_valid", {31'b0, bus.instr_valid}, 0);
    chk("rst_req_valid", {31'b0, bus.mem_req_valid}, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);
    sbq.delete();
    mq.delete();
    exp_fetch = 32'h0;
    acc_cnt = 0;
    last_t = 0;
    prev_stall = 0;
    prev_redir = 0;
    cur_stale = 0;
    bus.mem_rsp_valid = 0;
    bus.mem_rsp_data = 0;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    bus.mem_req_ready = rr;
    bus.instr_ready = ir;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cyc++;
  endtask

  always @(negedge clk) begin
    int st;
    logic [31:0] p;
    if (rst_n) begin
      st = (bus.mem_rsp_valid && cur_stale) ? 1 : 0;
      foreach (mq[i]) if (mq[i].stale) st++;
      chk("req_valid_credit", {31'b0, bus.mem_req_valid},
          {31'b0, !bus.redirect_valid && (sbq.size() + st < DEPTH)});
      if (prev_stall && !bus.redirect_valid) chk("req_addr_hold", bus.mem_req_addr, prev_addr);
      if (prev_redir) chk("flush_empty", {31'b0, bus.instr_valid}, 0);
      if (bus.redirect_valid) begin
        sbq.delete();
        foreach (mq[i]) mq[i].stale = 1;
        cur_stale = 1;
        exp_fetch = bus.redirect_pc & ~32'h3;
      end else begin
        if (bus.instr_valid && bus.instr_ready) begin
          if (sbq.size() == 0) chk("spurious_instr_valid", {31'b0, bus.instr_valid}, 0);
          else begin
            p = sbq.pop_front();
            chk("instr_pc", bus.instr_pc, p);
            chk("instr", bus.instr, p ^ KEY);
          end
        end
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          chk("req_addr", bus.mem_req_addr, exp_fetch);
          sbq.push_back(exp_fetch);
          last_t = (cyc + $urandom_range(lat_min, lat_max) > last_t) ?
                   cyc + $urandom_range(lat_min, lat_max) : last_t + 1;
          if (last_t <= cyc) last_t = cyc + 1;
          mq.push_back('{t: last_t, d: bus.mem_req_addr ^ KEY, stale: 0});
          exp_fetch += 32'd4;
          acc_cnt++;
        end
      end
      prev_stall = bus.mem_req_valid && !bus.mem_req_ready;
      prev_addr = bus.mem_req_addr;
      prev_redir = bus.redirect_valid;
    end
  end

  initial begin
    bus.mem_req_ready = 0;
    bus.mem_rsp_valid = 0;
    bus.mem_rsp_data = 0;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    bus.instr_ready = 0;
    // streaming at latency 1: first word visible two cycles after its request
    lat_min = 1;
    lat_max = 1;
    do_reset(1, 1);
    @(negedge clk);
    #1;
    chk("p1_first_addr", bus.mem_req_addr, 32'h0);
    chk("p1_valid_c0", {31'b0, bus.instr_valid}, 0);
    step(1, 1, 0, 0);
    @(negedge clk);
    #1;
    chk("p1_valid_c1", {31'b0, bus.instr_valid}, 0);
    chk("p1_addr_c1", bus.mem_req_addr, 32'h4);
    step(1, 1, 0, 0);
    @(negedge clk);
    #1;
    chk("p1_valid_c2", {31'b0, bus.instr_valid}, 1);
    chk("p1_pc_c2", bus.instr_pc, 32'h0);
    chk("p1_instr_c2", bus.instr, 32'hA5A5_0000);
    run(10, 1, 1);
    // core stalled: credit stops fetch after DEPTH requests
    do_reset(1, 0);
    run(8, 1, 0);
    @(negedge clk);
    #1;
    chk("p2_accepts", acc_cnt, 4);
    chk("p2_req_valid", {31'b0, bus.mem_req_valid}, 0);
    run(12, 1, 1);
    chk("p2_resume", {31'b0, acc_cnt > 4}, 1);
    // latency 3 redirect with requests in flight
    lat_min = 3;
    lat_max = 3;
    do_reset(1, 1);
    run(2, 1, 1);
    step(1, 1, 1, 32'h100);
    run(14, 1, 1);
    // misaligned redirect coinciding with a pop
    lat_min = 1;
    lat_max = 1;
    run(4, 1, 1);
    step(1, 1, 0, 0);
    @(negedge clk);
    #1;
    chk("p4_head_valid", {31'b0, bus.instr_valid}, 1);
    step(1, 1, 1, 32'h102);
    run(10, 1, 1);
    // address wrap and back-to-back redirects
    step(1, 1, 1, 32'hFFFF_FFF8);
    run(8, 1, 1);
    lat_min = 3;
    lat_max = 3;
    run(3, 1, 1);
    step(1, 1, 1, 32'h200);
    step(1, 1, 1, 32'h300);
    run(14, 1, 1);
    // memory back-pressure holds the request address
    lat_min = 1;
    lat_max = 1;
    do_reset(1, 1);
    step(1, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 0);
      @(negedge clk);
      #1;
      chk("p5_hold_addr", bus.mem_req_addr, 32'h8);
      chk("p5_hold_valid", {31'b0, bus.mem_req_valid}, 1);
    end
    run(8, 1, 1);
    // reset mid-stream with words buffered
    do_reset(1, 0);
    run(4, 1, 0);
    @(negedge clk);
    #1;
    chk("p6_buffered", {31'b0, bus.instr_valid}, 1);
    do_reset(1, 1);
    run(12, 1, 1);
    // randomized traffic
    lat_min = 1;
    lat_max = 4;
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0, $urandom);
    run(20, 0, 1);
    chk("drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
Instruction prefetch stage sitting directly upstream of the single-cycle core's instruction port. It replaces the direct pc-to-instr_memory path with a decoupled fetcher:
- issues word-aligned fetch requests to a valid/ready instruction memory with variable response latency;
- buffers returned words in a small in-order FIFO;
- presents them to the core with a valid/ready handshake, each tagged with its PC.

Jumps and taken branches resolved in the core (jal, jalr, branch) arrive as a redirect. A redirect flushes the buffer and restarts fetch at the new PC.

Parameters:
DEPTH, 4, max instructions buffered plus in flight (credit limit); power of two, >=2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mem_req_valid  output  1  fetch request valid
mem_req_ready  input  1  memory accepts request this cycle
mem_req_addr  output  32  fetch byte address, bits[1:0] always 0
mem_rsp_valid  input  1  response word valid; in order, one per accepted request, never back-pressured
mem_rsp_data  input  32  response instruction word
redirect_valid  input  1  core redirect (jal/jalr/taken branch)
redirect_pc  input  32  redirect target
instr_valid  output  1  instr/instr_pc valid to core
instr  output  32  instruction word at FIFO head
instr_pc  output  32  PC of that instruction
instr_ready  input  1  core consumes head this cycle

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC; FIFO empty; inflight=0; drop_cnt=0. Outputs: mem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
- Credit: mem_req_valid = !redirect_valid && (fifo_count + inflight < DEPTH). Combinational from registered state and redirect_valid only.
- mem_req_addr = fetch_pc. It stays stable while mem_req_valid && !mem_req_ready.
- Request accept (valid&&ready): fetch_pc += 4 (wraps mod 2^32); inflight += 1.
- Response with drop_cnt==0: {fetch tag PC, data} pushed into FIFO.
  - Tag PC is taken from the rsp_pc register, which starts at fetch restart PC and advances by 4 per non-dropped response.
- Response with drop_cnt>0: discarded; drop_cnt -= 1.
- Any response: inflight -= 1. Accept and response in the same cycle leave inflight unchanged.
- Space for every response is guaranteed by the credit rule, so overflow is impossible. Assert fifo_count<=DEPTH.
- Output: instr_valid = FIFO non-empty (registered storage, no bypass).
  - Minimum latency: request accept at cycle N, response at N+1, instr_valid at N+2.
  - Pop on instr_valid&&instr_ready; one instruction per cycle sustained when memory latency is 1.
- Redirect (priority over everything else that cycle):
  - FIFO flushed; fetch_pc and rsp_pc <= {redirect_pc[31:2],2'b00}. Misaligned targets are silently aligned.
  - Any pop that cycle is ignored.
  - No request is issued that cycle.
  - drop_cnt <= inflight_next, i.e. the count still outstanding after this cycle's response accounting. A same-cycle response is dropped or counted normally first.
  - instr_valid=0 the following cycle.
- Back-to-back redirects: the second overrides; drop_cnt recomputed the same way, so no stale word is ever delivered.
- Redirect while mem_req_valid&&!mem_req_ready was pending: the request is withdrawn. This is legal because the memory only samples on valid&&ready.
- instr_ready while instr_valid=0: no effect.

Decomposition:
- Shared package ifetch_pkg: RESET_PC default, DEPTH default, CNT_W=$clog2(DEPTH+1), and a fetch-entry struct {pc[31:0], instr[31:0]}.
- One sub-module, ifetch_fifo: DEPTH-entry synchronous FIFO with push, pop, flush, count, and async active-low reset. The top holds the credit/drop counters and PC registers.

Test Plan:
1. Reset release; mem_req_ready=1; memory latency 1 returning addr^32'hA5A5_0000; instr_ready=1 -> mem_req_addr 0,4,8,... one per cycle. instr_valid first at cycle 2 with instr_pc=0, instr=32'hA5A5_0000, then one per cycle.
2. instr_ready=0 -> exactly 4 requests (0x0..0xC), then mem_req_valid=0. Raise instr_ready -> pops 0x0,0x4,... and requests resume at 0x10.
3. Latency 3, redirect_pc=0x100 while 2 requests are in flight -> both responses discarded. Next delivered instr_pc=0x100, with no instr_pc 0x8/0xC observed.
4. redirect_pc=0x102 -> next mem_req_addr=0x100 and instr_pc=0x100. Redirect in the same cycle as a pop -> old head not re-delivered; FIFO empty next cycle.
5. mem_req_ready held 0 for 5 cycles -> mem_req_addr constant at 0x8, mem_req_valid held 1, no duplicate or skipped addresses after release.
6. rst_n pulled low mid-stream with 3 entries buffered -> instr_valid and mem_req_valid go 0 asynchronously. After release, fetch restarts at RESET_PC with no stale words delivered.
